tlc_param_fsm: RTL and testbench
================================

TLC_PARAM_FSM -- requirements
Module: tlc_param_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 5, dwell counter width in bits.
REQ-002 SHALL have parameter GREEN_T, default 10, minimum green dwell in cycles.
REQ-003 SHALL have parameter YELLOW_T, default 3, yellow dwell in cycles.
REQ-004 SHALL have parameter ALLRED_T, default 2, all-red clearance dwell in cycles.
REQ-005 SHALL have parameter WALK_T, default 8, pedestrian walk dwell in cycles.
REQ-006 SHALL have parameter FLASH_HALF, default 4, flash half-period in cycles.
REQ-007 SHALL have port clk  input  1  clock.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port ns_car  input  1  vehicle demand on the NS approach, level.
REQ-010 SHALL have port ew_car  input  1  vehicle demand on the EW approach, level.
REQ-011 SHALL have port ped_req  input  1  pedestrian push-button, one or more cycles wide.
REQ-012 SHALL have port flash  input  1  flash-mode request, level.
REQ-013 SHALL have ports ns_g, ns_y, ns_r  output  1 each  NS lamps.
REQ-014 SHALL have ports ew_g, ew_y, ew_r  output  1 each  EW lamps.
REQ-015 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-016 SHALL have port ped_wait  output  1  pending pedestrian request.
REQ-017 SHALL have port state_o  output  3  current state code.

Function
REQ-018 SHALL use a Moore FSM with the following state_o codes: NS_GRN=0, NS_YEL=1, AR_NS=2, EW_GRN=3, EW_YEL=4, AR_EW=5, WALK=6, FLASH=7.
REQ-019 SHALL decode lamps from the registered state.
- NS_GRN: ns_g, ew_r.
- NS_YEL: ns_y, ew_r.
- EW_GRN: ns_r, ew_g.
- EW_YEL: ns_r, ew_y.
- AR_*/WALK: ns_r, ew_r.
- WALK: additionally walk=1.
- FLASH: ns_y=ew_y=blink, all other lamps 0.
REQ-020 SHALL keep a CNT_W-bit dwell counter that clears to 0 on every state change, increments otherwise, and saturates at 2^CNT_W-1.
REQ-021 SHALL exit each timed state when counter==T-1, so the state lasts exactly T cycles:
- NS_YEL, EW_YEL use YELLOW_T.
- AR_NS, AR_EW use ALLRED_T.
- WALK uses WALK_T.
REQ-022 SHALL leave NS_GRN for NS_YEL only when counter>=GREEN_T-1 and (ew_car or ped_wait); otherwise NS_GRN holds indefinitely.
REQ-023 SHALL leave EW_GRN for EW_YEL only when counter>=GREEN_T-1 and (ns_car or ped_wait); otherwise EW_GRN holds indefinitely.
REQ-024 SHALL follow these sequences:
- NS_YEL->AR_NS->EW_GRN.
- EW_YEL->AR_EW, then AR_EW->WALK if ped_wait, else AR_EW->NS_GRN.
- WALK->NS_GRN.
REQ-025 SHALL set ped_wait on any cycle with ped_req=1 outside WALK, clear it on the edge that enters WALK, and ignore ped_req while in WALK.
REQ-026 SHALL treat a ped_req on the cycle before WALK entry as served (clear wins).
REQ-027 SHALL enter FLASH on the first edge where flash=1, from any state; flash has priority over all timed transitions.
REQ-028 SHALL, in FLASH:
- start blink=1;
- toggle blink and clear the counter when counter==FLASH_HALF-1.
REQ-029 SHALL, on flash=0 while in FLASH, go to AR_EW; ped_wait is retained across FLASH.
REQ-030 SHALL never assert green or yellow in both directions simultaneously; exactly one of g/y/r SHALL be 1 per direction outside FLASH.
REQ-031 SHALL require 1<=each T<2^CNT_W; an elaboration error SHALL be raised otherwise.

Reset
REQ-032 SHALL, on rst=1, immediately (asynchronously) force:
- state NS_GRN and counter 0;
- ped_wait=0, blink=1;
- outputs ns_g=1, ew_r=1, all others 0, state_o=0.
REQ-033 SHALL, on rst asserted mid-state (e.g. NS_YEL, WALK, FLASH), abandon the state and discard pending requests.

Configuration
REQ-034 SHALL compile AR_NS/AR_EW in when macro TLC_ALL_RED_EN is defined.
REQ-035 SHALL, without TLC_ALL_RED_EN, omit both all-red states:
- NS_YEL->EW_GRN;
- EW_YEL->WALK or NS_GRN per REQ-024;
- FLASH exit->NS_GRN, or WALK if ped_wait;
- state codes 2 and 5 SHALL be unreachable.

Verification
REQ-036 SHALL check: defaults, macro on, ns_car=ew_car=1, no ped -> NS_G 10, NS_Y 3, AR 2, EW_G 10, EW_Y 3, AR 2; period 30 cycles repeating.
REQ-037 SHALL check: ew_car=0, ped idle -> NS_G held 50 cycles; raise ew_car at cycle 50 -> NS_Y on the next edge.
REQ-038 SHALL check: 1-cycle ped_req at NS_GRN cycle 2, no cars -> ped_wait=1; sequence NS_G 10, NS_Y 3, AR 2, EW_G 10, EW_Y 3, AR 2, WALK 8 with walk=1 and all red; ped_wait=0 from WALK entry; then NS_GRN.
REQ-039 SHALL check: flash=1 at EW_GRN cycle 5 -> state_o=7 next edge; ns_y=ew_y 1,1,1,1,0,0,0,0...; flash=0 -> AR_EW 2 cycles, then NS_GRN.
REQ-040 SHALL check: rst pulse mid NS_YEL with ped_wait=1 -> immediately state_o=0, ns_g=1, ew_r=1, ped_wait=0.
REQ-041 SHALL check: macro off, both cars -> NS_G 10, NS_Y 3, EW_G 10, EW_Y 3; period 26; state_o never 2 or 5.

Source files
------------

// File: rtl/tlc_param_fsm.sv
// Parameterised traffic-light controller with pedestrian walk phase and flash mode.
// Define TLC_ALL_RED_EN to compile in the all-red clearance states AR_NS/AR_EW.
module tlc_param_fsm #(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned GREEN_T    = 10,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 2,
    parameter int unsigned WALK_T     = 8,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    input  logic       flash,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] state_o
);

    localparam int unsigned TMAX = (1 << CNT_W);

    if (GREEN_T < 1 || GREEN_T >= TMAX || YELLOW_T < 1 || YELLOW_T >= TMAX ||
        ALLRED_T < 1 || ALLRED_T >= TMAX || WALK_T < 1 || WALK_T >= TMAX ||
        FLASH_HALF < 1 || FLASH_HALF >= TMAX) begin : g_bad_param
        $error("tlc_param_fsm: every dwell parameter must satisfy 1 <= T < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] GRN_END = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YEL_END = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] WLK_END = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLS_END = CNT_W'(FLASH_HALF - 1);
`ifdef TLC_ALL_RED_EN
    localparam logic [CNT_W-1:0] AR_END  = CNT_W'(ALLRED_T - 1);
`endif

    typedef enum logic [2:0] {
        StNsGrn = 3'd0,
        StNsYel = 3'd1,
        StArNs  = 3'd2,
        StEwGrn = 3'd3,
        StEwYel = 3'd4,
        StArEw  = 3'd5,
        StWalk  = 3'd6,
        StFlash = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_wait_q, ped_wait_d;
    logic             blink_q, blink_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StNsGrn;
            cnt_q      <= '0;
            ped_wait_q <= 1'b0;
            blink_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_wait_q <= ped_wait_d;
            blink_q    <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flash) begin
            state_d = StFlash;
        end else begin
            unique case (state_q)
                StNsGrn: if (cnt_q >= GRN_END && (ew_car || ped_wait_q)) state_d = StNsYel;
`ifdef TLC_ALL_RED_EN
                StNsYel: if (cnt_q == YEL_END) state_d = StArNs;
                StArNs:  if (cnt_q == AR_END) state_d = StEwGrn;
                StEwGrn: if (cnt_q >= GRN_END && (ns_car || ped_wait_q)) state_d = StEwYel;
                StEwYel: if (cnt_q == YEL_END) state_d = StArEw;
                StArEw:  if (cnt_q == AR_END) state_d = ped_wait_q ? StWalk : StNsGrn;
                StFlash: state_d = StArEw;
`else
                StNsYel: if (cnt_q == YEL_END) state_d = StEwGrn;
                StEwGrn: if (cnt_q >= GRN_END && (ns_car || ped_wait_q)) state_d = StEwYel;
                StEwYel: if (cnt_q == YEL_END) state_d = ped_wait_q ? StWalk : StNsGrn;
                StFlash: state_d = ped_wait_q ? StWalk : StNsGrn;
`endif
                StWalk:  if (cnt_q == WLK_END) state_d = StNsGrn;
                default: state_d = StNsGrn;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StFlash && cnt_q == FLS_END) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Blink restarts lit on every FLASH entry.
        blink_d = 1'b1;
        if (state_d == StFlash && state_q == StFlash) begin
            blink_d = (cnt_q == FLS_END) ? ~blink_q : blink_q;
        end

        // Entering WALK serves the request, even one arriving on the same edge.
        ped_wait_d = ped_wait_q;
        if (state_d == StWalk && state_q != StWalk) begin
            ped_wait_d = 1'b0;
        end else if (ped_req && state_q != StWalk) begin
            ped_wait_d = 1'b1;
        end
    end

    always_comb begin
        ns_g = 1'b0;
        ns_y = 1'b0;
        ns_r = 1'b0;
        ew_g = 1'b0;
        ew_y = 1'b0;
        ew_r = 1'b0;
        walk = 1'b0;
        unique case (state_q)
            StNsGrn: begin ns_g = 1'b1; ew_r = 1'b1; end
            StNsYel: begin ns_y = 1'b1; ew_r = 1'b1; end
            StEwGrn: begin ns_r = 1'b1; ew_g = 1'b1; end
            StEwYel: begin ns_r = 1'b1; ew_y = 1'b1; end
            StWalk:  begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
            StFlash: begin ns_y = blink_q; ew_y = blink_q; end
            default: begin ns_r = 1'b1; ew_r = 1'b1; end
        endcase
    end

    assign ped_wait = ped_wait_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_tlc_param_fsm.sv
// Bench for tlc_param_fsm: directed scenarios plus random traffic, all checked each
// cycle against a dwell-time reference model.
module tb_tlc_param_fsm;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned GREEN_T    = 10;
    localparam int unsigned YELLOW_T   = 3;
    localparam int unsigned ALLRED_T   = 2;
    localparam int unsigned WALK_T     = 8;
    localparam int unsigned FLASH_HALF = 4;
`ifdef TLC_ALL_RED_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic ns_car = 1'b0, ew_car = 1'b0, ped_req = 1'b0, flash = 1'b0;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    tlc_param_fsm #(
        .CNT_W(CNT_W), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
        .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk), .rst(rst), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
        .flash(flash), .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y),
        .ew_r(ew_r), .walk(walk), .ped_wait(ped_wait), .state_o(state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase code, cycles spent in it, pending pedestrian flag.
    int m_state = 0;
    int m_age   = 0;
    bit m_pw    = 1'b0;

    function automatic void model_reset();
        m_state = 0;
        m_age   = 0;
        m_pw    = 1'b0;
    endfunction

    function automatic void model_step();
        int nxt;
        int done;
        nxt  = m_state;
        done = m_age + 1;
        if (flash) nxt = 7;
        else begin
            case (m_state)
                0: if (done >= int'(GREEN_T) && (ew_car || m_pw)) nxt = 1;
                1: if (done == int'(YELLOW_T)) nxt = AR ? 2 : 3;
                2: if (done == int'(ALLRED_T)) nxt = 3;
                3: if (done >= int'(GREEN_T) && (ns_car || m_pw)) nxt = 4;
                4: if (done == int'(YELLOW_T)) nxt = AR ? 5 : (m_pw ? 6 : 0);
                5: if (done == int'(ALLRED_T)) nxt = m_pw ? 6 : 0;
                6: if (done == int'(WALK_T)) nxt = 0;
                default: nxt = AR ? 5 : (m_pw ? 6 : 0);
            endcase
        end
        if (nxt == 6 && m_state != 6) m_pw = 1'b0;
        else if (ped_req && m_state != 6) m_pw = 1'b1;
        m_age   = (nxt != m_state) ? 0 : m_age + 1;
        m_state = nxt;
    endfunction

    // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    function automatic logic [6:0] exp_lamps();
        bit b;
        b = ((m_age / int'(FLASH_HALF)) % 2) == 0;
        case (m_state)
            0: return 7'b100_001_0;
            1: return 7'b010_001_0;
            3: return 7'b001_100_0;
            4: return 7'b001_010_0;
            6: return 7'b001_001_1;
            7: return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
            default: return 7'b001_001_0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "/state"}, 16'(state_o), 16'(m_state));
        chk({tag, "/lamps"}, 16'({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}), 16'(exp_lamps()));
        chk({tag, "/ped_wait"}, 16'(ped_wait), 16'(m_pw));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare("rst_async");
        cyc("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int nwalk;
        bit left;
        bit done;

        #1 rst = 1'b1;
        #1;
        model_reset();
        compare("reset");
        cyc("reset_edge");
        rst = 1'b0;

        // Both approaches busy: full cycle period.
        ns_car = 1'b1;
        ew_car = 1'b1;
        t = 0; left = 1'b0; done = 1'b0;
        while (!done && t < 100) begin
            cyc("cars");
            t++;
            if (state_o != 3'd0) left = 1'b1;
            else if (left) done = 1'b1;
        end
        chk("period", 16'(t), AR ? 16'd30 : 16'd26);
        for (int i = 0; i < 40; i++) cyc("cars_run");

        // Bring back to NS_GRN entry, then hold with no demand.
        t = 0;
        while (!(state_o == 3'd0 && m_age == 0) && t < 60) begin cyc("align"); t++; end
        ns_car = 1'b0;
        ew_car = 1'b0;
        for (int i = 0; i < 50; i++) cyc("hold");
        chk("hold50", 16'(state_o), 16'd0);
        ew_car = 1'b1;
        cyc("ew_arrive");
        chk("ew_to_nsy", 16'(state_o), 16'd1);
        ew_car = 1'b0;

        // Flash during EW_GRN, then release.
        t = 0;
        while (!(state_o == 3'd3 && m_age == 5) && t < 40) begin cyc("to_ewg"); t++; end
        flash = 1'b1;
        cyc("flash_in");
        chk("flash_code", 16'(state_o), 16'd7);
        for (int i = 0; i < 12; i++) cyc("flash");
        flash = 1'b0;
        for (int i = 0; i < 16; i++) cyc("flash_out");

        // Pedestrian request at NS_GRN cycle 2, no cars.
        do_reset();
        cyc("ped_pre");
        ped_req = 1'b1;
        cyc("ped_req");
        ped_req = 1'b0;
        chk("ped_set", 16'(ped_wait), 16'd1);
        nwalk = 0;
        for (int i = 0; i < 50; i++) begin
            cyc("ped_seq");
            if (walk) nwalk++;
        end
        chk("walk_len", 16'(nwalk), 16'(WALK_T));

        // Asynchronous reset in the middle of NS_YEL with a pending request.
        do_reset();
        ew_car  = 1'b1;
        ped_req = 1'b1;
        cyc("pre_nsy");
        ped_req = 1'b0;
        t = 0;
        while (state_o != 3'd1 && t < 40) begin cyc("to_nsy"); t++; end
        chk("reach_nsy", 16'(state_o), 16'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_state", 16'(state_o), 16'd0);
        chk("mid_rst_lamps", 16'({ns_g, ew_r, ped_wait}), 16'b110);
        cyc("mid_rst_hold");
        rst = 1'b0;
        ew_car = 1'b0;

        // Random traffic, pedestrians, flash and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) ns_car = ~ns_car;
            if ($urandom_range(7) == 0) ew_car = ~ew_car;
            ped_req = ($urandom_range(19) == 0);
            if ($urandom_range(59) == 0) flash = ~flash;
            rst = ($urandom_range(299) == 0);
            cyc("rand");
            if (state_o == 3'd7 && $urandom_range(3) == 0 && flash) flash = 1'b0;
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
